// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
// The slave modport is the controller; the master modport is the requester/consumer.
interface nibble_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_sub;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_ovf;
  logic             o_zero;

  modport slave (
    input  i_valid, i_a, i_b, i_sub, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_ovf, o_zero
  );

  modport master (
    output i_valid, i_a, i_b, i_sub, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_ovf, o_zero
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single 4-bit CLA.
// Optional overflow/zero flags are enabled by defining NIBBLE_SERIAL_FLAGS_EN.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_add_ctrl_if.slave  bus
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cy_q, cy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [3:0] nib_a, nib_b, nib_g, nib_p, nib_c, nib_sum;
  logic       nib_cout;
  logic       last_step;

  // 4-bit carry-lookahead adder on the low nibble of the shifting operand registers.
  always_comb begin
    nib_a    = a_q[3:0];
    nib_b    = b_q[3:0];
    nib_g    = nib_a & nib_b;
    nib_p    = nib_a ^ nib_b;
    nib_c[0] = cy_q;
    nib_c[1] = nib_g[0] | (nib_p[0] & cy_q);
    nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0]) | (nib_p[1] & nib_p[0] & cy_q);
    nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1]) | (nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[2] & nib_p[1] & nib_p[0] & cy_q);
    nib_cout = nib_g[3] | (nib_p[3] & nib_g[2]) | (nib_p[3] & nib_p[2] & nib_g[1])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
             | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & cy_q);
    nib_sum  = nib_p ^ nib_c;
  end

  assign last_step = (cnt_q == CNT_W'(NIB - 1));

`ifdef NIBBLE_SERIAL_FLAGS_EN
  logic nz_q, nz_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`ifdef NIBBLE_SERIAL_FLAGS_EN
    nz_d     = nz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_valid && ready_q) begin
          a_d     = bus.i_a;
          b_d     = bus.i_b ^ {WIDTH{bus.i_sub}};
          cy_d    = bus.i_sub;
          cnt_d   = '0;
          state_d = RUN;
`ifdef NIBBLE_SERIAL_FLAGS_EN
          nz_d    = 1'b0;
`endif
        end
      end
      RUN: begin
        result_d[{cnt_q, 2'b00} +: 4] = nib_sum;
        // Operands shift down so the next nibble is always at [3:0].
        a_d  = a_q >> 4;
        b_d  = b_q >> 4;
        cy_d = nib_cout;
`ifdef NIBBLE_SERIAL_FLAGS_EN
        nz_d = nz_q | (|nib_sum);
`endif
        if (last_step) begin
          cnt_d   = '0;
          state_d = DONE;
          valid_d = 1'b1;
          carry_d = nib_cout;
`ifdef NIBBLE_SERIAL_FLAGS_EN
          // On the last step nibble bit 3 is the operand sign bit.
          ovf_d  = (nib_a[3] == nib_b[3]) && (nib_sum[3] != nib_a[3]);
          zero_d = ~(nz_q | (|nib_sum));
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

`ifdef NIBBLE_SERIAL_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nz_q <= 1'b0;
    else        nz_q <= nz_d;
  end
`endif

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_carry  = carry_q;
  assign bus.o_ovf    = ovf_q;
  assign bus.o_zero   = zero_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=32); honours NIBBLE_SERIAL_FLAGS_EN.
module tb_nibble_serial_add_ctrl;

`ifdef NIBBLE_SERIAL_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(32)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait for o_valid; leaves the result pending in DONE.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub);
    int n;
    @(negedge clk);
    bus.i_a = a; bus.i_b = b; bus.i_sub = sub; bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_a = 32'hDEAD_BEEF; bus.i_b = 32'h0BAD_F00D; bus.i_sub = ~sub;
    check({tag, " ready_low"}, 32'(bus.o_ready), 32'd0);
    n = 0;
    while (!bus.o_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(n), 32'd8);
  endtask

  task automatic check_result(input string tag, input logic [31:0] res, input logic c,
                              input logic ovf, input logic zero);
    check({tag, " result"}, bus.o_result, res);
    check({tag, " carry"}, 32'(bus.o_carry), 32'(c));
    check({tag, " ovf"}, 32'(bus.o_ovf), 32'(ovf & FLAGS));
    check({tag, " zero"}, 32'(bus.o_zero), 32'(zero & FLAGS));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({tag, " valid_drop"}, 32'(bus.o_valid), 32'd0);
    check({tag, " ready_back"}, 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    bus.i_a = '0; bus.i_b = '0; bus.i_sub = 1'b0;
    #12;
    check("rst ready", 32'(bus.o_ready), 32'd1);
    check("rst valid", 32'(bus.o_valid), 32'd0);
    check("rst result", bus.o_result, 32'd0);
    check("rst carry", 32'(bus.o_carry), 32'd0);
    rst_n = 1'b1;

    start_op("add5_3", 32'h0000_0005, 32'h0000_0003, 1'b0);
    check_result("add5_3", 32'h0000_0008, 1'b0, 1'b0, 1'b0);
    release_result("add5_3");

    start_op("addwrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check_result("addwrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    release_result("addwrap");

    start_op("sub5_7", 32'h0000_0005, 32'h0000_0007, 1'b1);
    check_result("sub5_7", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    release_result("sub5_7");

    start_op("sub7_5", 32'h0000_0007, 32'h0000_0005, 1'b1);
    check_result("sub7_5", 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    release_result("sub7_5");

    start_op("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check_result("addovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    release_result("addovf");

    start_op("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1);
    check_result("subovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    release_result("subovf");

    // Backpressure: result must hold while the consumer stalls.
    start_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b0);
    check_result("bp", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    held = bus.o_result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.i_valid = ~bus.i_valid;
      bus.i_a = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("bp valid", 32'(bus.o_valid), 32'd1);
      check("bp hold", bus.o_result, held);
      check("bp ready", 32'(bus.o_ready), 32'd0);
    end
    bus.i_valid = 1'b0;
    release_result("bp");
    start_op("after_bp", 32'h0000_0001, 32'h0000_0001, 1'b0);
    check_result("after_bp", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    release_result("after_bp");

    // Asynchronous reset in the middle of RUN step 3.
    @(negedge clk);
    bus.i_a = 32'hAAAA_AAAA; bus.i_b = 32'h5555_5555; bus.i_sub = 1'b0; bus.i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst ready", 32'(bus.o_ready), 32'd1);
    check("arst valid", 32'(bus.o_valid), 32'd0);
    check("arst result", bus.o_result, 32'd0);
    check("arst carry", 32'(bus.o_carry), 32'd0);
    check("arst ovf", 32'(bus.o_ovf), 32'd0);
    check("arst zero", 32'(bus.o_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b0);
    check_result("post_rst", 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    release_result("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
